seq_timing_elastic_pipe: RTL and testbench
==========================================

# seq_timing_elastic_pipe

Parametrised elastic register pipeline: a sequential benchmark for timing extraction in the SystemVerilog frontend. It carries WIDTH-bit data through DEPTH valid/ready-handshaked stages, all clocked on a single supported clock event (rising `clk`) with asynchronous active-low reset. It generalises the single 8-bit reset register to configurable width and depth, adding backpressure, flush and occupancy reporting. Every register is written only from `always_ff @(posedge clk or negedge rst)`, with no delay controls.

## Interface
- WIDTH, 8: data width in bits, ≥1.
- DEPTH, 3: number of pipeline stages, ≥1.
- RESET_VALUE, 0: value loaded into every stage data register on reset, WIDTH bits.
- CW, $clog2(DEPTH+1): width of `occupancy`. Derived; not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; one clock, async active-low reset.
- flush  input  1  synchronous clear of all stage valid bits.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  pipeline accepts `in_data` this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream accepts `out_data` this cycle.
- out_data  output  WIDTH  last stage data.
- occupancy  output  CW  number of valid stages, 0..DEPTH.

## Operation
- State per stage i (0..DEPTH-1): `v[i]` (valid) and `d[i]` (WIDTH data). Stage 0 is the input side; stage DEPTH-1 drives `out_data`/`out_valid`.
- Advance condition: `adv[DEPTH-1] = !v[DEPTH-1] | out_ready`; `adv[i] = !v[i] | adv[i+1]` for i < DEPTH-1. This is a combinational ready chain with no bubbles required.
- `in_ready = adv[0]`. Input is accepted when `in_valid & in_ready`.
- On an edge with `adv[i]`:
  - Stage 0 loads `v[0] <= in_valid` and `d[0] <= in_data` when `in_valid`.
  - Stage i>0 loads `v[i] <= v[i-1]` and `d[i] <= d[i-1]` when `v[i-1]`.
  - Data of a stage with an invalid source is not updated, to save toggles. Its value is don't-care but deterministic (it holds).
- Without `adv[i]`: stage i holds `v[i]` and `d[i]`.
- `out_data`/`out_valid` stay stable while `out_valid & !out_ready`.
- `occupancy` = popcount of `v[]`. It is combinational from registered bits and never exceeds DEPTH.
- `flush` = 1 at an edge:
  - All `v[]` go to 0. Flush overrides advance.
  - An input offered in the flush cycle is dropped, even though `in_ready` may read 1.
  - `d[]` is unchanged.
- Reset (`rst` = 0): immediately and asynchronously, `v[]` = 0 and `d[]` = RESET_VALUE. This holds regardless of clock, including mid-transfer. The first update occurs on the first rising `clk` after `rst` rises.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = RESET_VALUE, `occupancy` = 0.
  - `in_ready` = 1 (all stages empty).
- Latency: data accepted at edge N appears on `out_data` with `out_valid` = 1 after edge N+DEPTH-1. That is DEPTH register stages, measured with no stalls.
- Throughput: 1 word/cycle when `out_ready` is held at 1.
- Full (`occupancy` = DEPTH) with `out_ready` = 0: `in_ready` = 0, and all state holds.
- Full with `out_ready` = 1: the whole chain shifts, `in_ready` = 1, and a simultaneous accept and emit leaves `occupancy` = DEPTH.
- Bubble collapse: an empty stage ahead of a stalled stage still fills. `occupancy` rises by 1 per edge while input is offered, until full.
- `in_ready` depends combinationally on `out_ready`. There is no registered ready; this path is intentional and is part of what the benchmark exercises.
- DEPTH=1 degenerates to a single handshaked register: `in_ready = !v[0] | out_ready`.

## Test plan
- Reset: hold `rst` = 0 with RESET_VALUE=8'hA5 and toggle `clk` → `out_valid` = 0, `out_data` = 8'hA5, `occupancy` = 0, `in_ready` = 1. Assert `rst` low mid-stream with `occupancy` = 2 → all three outputs clear with no clock edge.
- Streaming (WIDTH=8, DEPTH=3): `out_ready` = 1, inputs 8'h01, 8'h02, 8'h03 on consecutive edges → `out_data` = 01, 02, 03 on the 3rd, 4th and 5th edges, with `out_valid` high on each.
- Backpressure fill: `out_ready` = 0, offer 8'h10..8'h14 → exactly 10, 11, 12 accepted, `in_ready` = 0 after the 3rd edge, `occupancy` = 3, `out_data` = 8'h10 held stable.
- Full with simultaneous transfer: from the full state, set `out_ready` = 1 and `in_valid` = 1 with 8'h13 → 8'h10 emitted, 8'h13 accepted, `occupancy` stays 3, next `out_data` = 8'h11.
- Flush: `occupancy` = 2 and `in_valid` = 1 with 8'hFF at the flush edge → `occupancy` = 0, `out_valid` = 0 next cycle, and 8'hFF never appears at the output.
- DEPTH=1, WIDTH=16: alternate `out_ready` 0/1 with continuous input → `in_ready` mirrors the `!v | out_ready` rule and no word is lost or duplicated.

Source files
------------

// File: rtl/seq_timing_elastic_pipe.sv
// seq_timing_elastic_pipe
// Elastic register pipeline of DEPTH valid/ready stages carrying WIDTH-bit
// words. Ready propagates combinationally from out_ready back to in_ready, so
// a full chain can shift every cycle. An empty stage in front of a stalled
// stage still fills, so bubbles collapse. flush clears every valid bit but
// leaves data untouched. occupancy reports how many stages hold valid data.
module seq_timing_elastic_pipe #(
  parameter int                 WIDTH       = 8,
  parameter int                 DEPTH       = 3,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  localparam int                CW          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    occupancy
);

  // Stage state: index 0 is the input side, DEPTH-1 drives the outputs.
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];

  // Per-stage advance enable and the valid/data each stage would load.
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];

  // Ready chain: stage i may advance when out_ready is high or any stage at
  // or beyond i is empty. This is the closed form of
  // adv[i] = !v[i] | adv[i+1], computed without a self-referencing vector.
  always_comb begin : ready_chain
    logic tail_full;
    tail_full = 1'b1;
    adv       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      tail_full = tail_full & v[i];
      adv[i]    = out_ready | ~tail_full;
    end
  end

  // Source of each stage: upstream port for stage 0, previous stage otherwise.
  always_comb begin
    src_v    = '0;
    src_v[0] = in_valid;
    src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  // Valid bits: flush wins over advance; a stalled stage holds its valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i]) v[i] <= src_v[i];
      end
    end
  end

  // Data: only load from a valid source so idle stages do not toggle;
  // flush leaves data as it was.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) d[i] <= RESET_VALUE;
    end else if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i] && src_v[i]) d[i] <= src_d[i];
      end
    end
  end

  // Occupancy is the popcount of the registered valid bits.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + CW'(v[i]);
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_seq_timing_elastic_pipe.sv
// Directed bench for seq_timing_elastic_pipe: a WIDTH=8/DEPTH=3 instance with
// RESET_VALUE=8'hA5, and a WIDTH=16/DEPTH=1 instance for the degenerate case.
module tb_seq_timing_elastic_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // DEPTH=3 instance signals
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] occupancy;

  // DEPTH=1 instance signals
  logic        flush1 = 1'b0;
  logic        in1_valid = 1'b0;
  logic        in1_ready;
  logic [15:0] in1_data = 16'h0000;
  logic        out1_valid;
  logic        out1_ready = 1'b0;
  logic [15:0] out1_data;
  logic [0:0]  occupancy1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  seq_timing_elastic_pipe #(
    .WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  seq_timing_elastic_pipe #(
    .WIDTH(16), .DEPTH(1), .RESET_VALUE(16'h0000)
  ) dut1 (
    .clk(clk), .rst(rst), .flush(flush1),
    .in_valid(in1_valid), .in_ready(in1_ready), .in_data(in1_data),
    .out_valid(out1_valid), .out_ready(out1_ready), .out_data(out1_data),
    .occupancy(occupancy1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 8'hA5) $display("FAIL rst_out_data: got %h want a5", out_data); else pass_cnt++;
    total_cnt++; if (occupancy !== 2'd0) $display("FAIL rst_occupancy: got %0d want 0", occupancy); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (in1_ready !== 1'b1) $display("FAIL rst_d1_in_ready: got %b want 1", in1_ready); else pass_cnt++;
    rst = 1'b1;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h01;
    tick();
    total_cnt++; if (occupancy !== 2'd1) $display("FAIL stream_occ1: got %0d want 1", occupancy); else pass_cnt++;
    in_data = 8'h02;
    tick();
    total_cnt++; if (occupancy !== 2'd2) $display("FAIL stream_occ2: got %0d want 2", occupancy); else pass_cnt++;
    in_data = 8'h03;
    tick();
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h01) $display("FAIL stream_out1: got v=%b d=%h want v=1 d=01", out_valid, out_data); else pass_cnt++;
    total_cnt++; if (occupancy !== 2'd3) $display("FAIL stream_occ3: got %0d want 3", occupancy); else pass_cnt++;
    in_valid = 1'b0;
    tick();
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h02) $display("FAIL stream_out2: got v=%b d=%h want v=1 d=02", out_valid, out_data); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h03) $display("FAIL stream_out3: got v=%b d=%h want v=1 d=03", out_valid, out_data); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b0 || occupancy !== 2'd0) $display("FAIL stream_drain: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h10;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready0: got %b want 1", in_ready); else pass_cnt++;
    tick();
    in_data = 8'h11;
    tick();
    in_data = 8'h12;
    tick();
    total_cnt++; if (occupancy !== 2'd3) $display("FAIL bp_occ_full: got %0d want 3", occupancy); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready_full: got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h10) $display("FAIL bp_out_head: got v=%b d=%h want v=1 d=10", out_valid, out_data); else pass_cnt++;
    // 8'h13 and 8'h14 are offered while stalled and must not enter.
    in_data = 8'h13;
    tick();
    in_data = 8'h14;
    tick();
    total_cnt++; if (occupancy !== 2'd3 || in_ready !== 1'b0) $display("FAIL bp_hold: got occ=%0d rdy=%b want occ=3 rdy=0", occupancy, in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h10) $display("FAIL bp_out_stable: got v=%b d=%h want v=1 d=10", out_valid, out_data); else pass_cnt++;
  endtask

  task automatic test_full_transfer();
    in_data   = 8'h13;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL full_ready_comb: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_data !== 8'h10) $display("FAIL full_emit: got %h want 10", out_data); else pass_cnt++;
    tick();
    in_valid = 1'b0;
    total_cnt++; if (occupancy !== 2'd3) $display("FAIL full_occ_keep: got %0d want 3", occupancy); else pass_cnt++;
    total_cnt++; if (out_data !== 8'h11) $display("FAIL full_next: got %h want 11", out_data); else pass_cnt++;
    tick();
    total_cnt++; if (out_data !== 8'h12) $display("FAIL full_drain12: got %h want 12", out_data); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h13) $display("FAIL full_drain13: got v=%b d=%h want v=1 d=13", out_valid, out_data); else pass_cnt++;
    tick();
    total_cnt++; if (occupancy !== 2'd0) $display("FAIL full_empty: got %0d want 0", occupancy); else pass_cnt++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h20;
    tick();
    in_data = 8'h21;
    tick();
    total_cnt++; if (occupancy !== 2'd2) $display("FAIL flush_pre_occ: got %0d want 2", occupancy); else pass_cnt++;
    in_data = 8'hFF;
    flush   = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", in_ready); else pass_cnt++;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total_cnt++; if (occupancy !== 2'd0 || out_valid !== 1'b0) $display("FAIL flush_clear: got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      tick();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_no_ff%0d: got v=%b d=%h want v=0", k, out_valid, out_data); else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h30;
    tick();
    in_data = 8'h31;
    tick();
    in_valid = 1'b0;
    total_cnt++; if (occupancy !== 2'd2) $display("FAIL areset_pre_occ: got %0d want 2", occupancy); else pass_cnt++;
    #2;
    rst = 1'b0;
    #1;
    total_cnt++; if (occupancy !== 2'd0) $display("FAIL areset_occ: got %0d want 0", occupancy); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL areset_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 8'hA5) $display("FAIL areset_data: got %h want a5", out_data); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL areset_ready: got %b want 1", in_ready); else pass_cnt++;
    rst = 1'b1;
    tick();
  endtask

  // DEPTH=1: a single handshaked register with in_ready = !v | out_ready.
  task automatic test_depth1();
    logic        mv;
    logic [15:0] md;
    logic [15:0] next_in;
    logic [15:0] next_out;
    mv       = 1'b0;
    md       = 16'h0000;
    next_in  = 16'hA000;
    next_out = 16'hA000;
    in1_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      out1_ready = k[0];
      in1_data   = next_in;
      #1;
      total_cnt++; if (in1_ready !== (~mv | out1_ready)) $display("FAIL d1_ready%0d: got %b want %b", k, in1_ready, ~mv | out1_ready); else pass_cnt++;
      if (mv && out1_ready) begin
        total_cnt++; if (out1_data !== next_out) $display("FAIL d1_emit%0d: got %h want %h", k, out1_data, next_out); else pass_cnt++;
        next_out = next_out + 16'd1;
      end
      if (~mv | out1_ready) begin
        mv      = 1'b1;
        md      = next_in;
        next_in = next_in + 16'd1;
      end
      tick();
      total_cnt++; if (out1_valid !== mv || out1_data !== md || occupancy1 !== mv) $display("FAIL d1_state%0d: got v=%b d=%h occ=%0d want v=%b d=%h", k, out1_valid, out1_data, occupancy1, mv, md); else pass_cnt++;
    end
    in1_valid = 1'b0;
    // Ten cycles with ready on odd cycles: six words in, five out, one held.
    total_cnt++; if (next_out !== 16'hA005 || next_in !== 16'hA006) $display("FAIL d1_count: got out=%h in=%h want out=a005 in=a006", next_out, next_in); else pass_cnt++;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_full_transfer();
    test_flush();
    test_async_reset();
    test_depth1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
